// File: rtl/pipeline_pkg.sv
// Shared decode/execute pipeline types: control bundle, RV32I opcodes, stage actions.
// Latency: none (types and constants only).
// Backpressure: none; consumers apply en/no_op/flush themselves.
package pipeline_pkg;

   typedef struct packed {
      logic       reg_write_en;
      logic       mem_write_en;
      logic [1:0] result_src;
      logic [3:0] alu_ctrl;
      logic       alu_src;
      logic       jump;
      logic       branch;
   } de_ctrl_t;

   localparam logic [6:0] OP_LOAD    = 7'b0000011;
   localparam logic [6:0] OP_IMM     = 7'b0010011;
   localparam logic [6:0] OP_STORE   = 7'b0100011;
   localparam logic [6:0] OP_BRANCH  = 7'b1100011;
   localparam logic [6:0] OP_JAL     = 7'b1101111;
   localparam logic [6:0] OP_JALR    = 7'b1100111;
   localparam logic [6:0] OP_LUI     = 7'b0110111;
   localparam logic [6:0] OP_AUIPC   = 7'b0010111;

   // addi x0,x0,0 is the inert slot filler
   localparam logic [6:0] NOP_OPCODE = OP_IMM;

   typedef enum logic [1:0] {
      ACT_HOLD   = 2'd0,
      ACT_LOAD   = 2'd1,
      ACT_BUBBLE = 2'd2,
      ACT_FLUSH  = 2'd3
   } de_action_e;

   // Resolve the single action applied at a clock edge; flush beats bubble beats load.
   function automatic de_action_e de_action(input logic flush, input logic no_op, input logic en);
      de_action_e act;
      if (flush)      act = ACT_FLUSH;
      else if (no_op) act = ACT_BUBBLE;
      else if (en)    act = ACT_LOAD;
      else            act = ACT_HOLD;
      return act;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter: counts edges with inc high, sticks at all-ones.
// Latency: count reflects an inc one cycle after the edge that sampled it.
// Backpressure: none; inc is sampled every rising edge.
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             inc,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   // Next count: advance on inc unless already saturated
   always_comb begin
      cnt_d = cnt_q;
      if (inc && (cnt_q != {WIDTH{1'b1}})) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   // Counter register, cleared by reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

   assign count = cnt_q;

endmodule

// File: rtl/decode_execute_reg.sv
// Decode->execute pipeline register with hold, NOP bubble and flush; optional stats (DE_REG_STATS_EN).
// Latency: 1 cycle from d_* to e_*; no combinational input-to-output path.
// Backpressure: en=0 holds contents; no_op injects a NOP regardless of en; flush overrides everything.
module decode_execute_reg
   import pipeline_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            en,
   input  logic            no_op,
   input  logic            flush,
   input  logic            d_valid,
   input  logic [XLEN-1:0] d_pc,
   input  logic [XLEN-1:0] d_pc_plus4,
   input  logic [XLEN-1:0] d_rd1,
   input  logic [XLEN-1:0] d_rd2,
   input  logic [XLEN-1:0] d_imm,
   input  logic [4:0]      d_reg_a,
   input  logic [4:0]      d_reg_b,
   input  logic [4:0]      d_reg_d,
   input  logic [6:0]      d_opcode,
   input  logic [2:0]      d_funct3,
   input  de_ctrl_t        d_ctrl,
   output logic            e_valid,
   output logic [XLEN-1:0] e_pc,
   output logic [XLEN-1:0] e_pc_plus4,
   output logic [XLEN-1:0] e_rd1,
   output logic [XLEN-1:0] e_rd2,
   output logic [XLEN-1:0] e_imm,
   output logic [4:0]      e_reg_a,
   output logic [4:0]      e_reg_b,
   output logic [4:0]      e_reg_d,
   output logic [6:0]      e_opcode,
   output logic [2:0]      e_funct3,
   output de_ctrl_t        e_ctrl,
   output logic [31:0]     stall_cnt,
   output logic [31:0]     bubble_cnt,
   output logic [31:0]     flush_cnt
);

   typedef struct packed {
      logic            valid;
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc_plus4;
      logic [XLEN-1:0] rd1;
      logic [XLEN-1:0] rd2;
      logic [XLEN-1:0] imm;
      logic [4:0]      reg_a;
      logic [4:0]      reg_b;
      logic [4:0]      reg_d;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      de_ctrl_t        ctrl;
   } stage_t;

   // Data fields are zero rather than don't-care so a bubble is fully deterministic
   function automatic stage_t nop_stage();
      stage_t s;
      s        = '0;
      s.opcode = NOP_OPCODE;
      return s;
   endfunction

   de_action_e act;
   stage_t     stage_d;
   stage_t     stage_q;

   assign act = de_action(flush, no_op, en);

   // Select next stage contents from the edge's single action
   always_comb begin
      stage_d = stage_q;
      case (act)
         ACT_FLUSH,
         ACT_BUBBLE: stage_d = nop_stage();
         ACT_LOAD: begin
            stage_d.valid    = d_valid;
            stage_d.pc       = d_pc;
            stage_d.pc_plus4 = d_pc_plus4;
            stage_d.rd1      = d_rd1;
            stage_d.rd2      = d_rd2;
            stage_d.imm      = d_imm;
            stage_d.reg_a    = d_reg_a;
            stage_d.reg_b    = d_reg_b;
            stage_d.reg_d    = d_reg_d;
            stage_d.opcode   = d_opcode;
            stage_d.funct3   = d_funct3;
            stage_d.ctrl     = d_ctrl;
         end
         default: stage_d = stage_q;
      endcase
   end

   // Stage register; reset leaves the inert NOP image in place
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stage_q <= nop_stage();
      else        stage_q <= stage_d;
   end

   assign e_valid    = stage_q.valid;
   assign e_pc       = stage_q.pc;
   assign e_pc_plus4 = stage_q.pc_plus4;
   assign e_rd1      = stage_q.rd1;
   assign e_rd2      = stage_q.rd2;
   assign e_imm      = stage_q.imm;
   assign e_reg_a    = stage_q.reg_a;
   assign e_reg_b    = stage_q.reg_b;
   assign e_reg_d    = stage_q.reg_d;
   assign e_opcode   = stage_q.opcode;
   assign e_funct3   = stage_q.funct3;
   assign e_ctrl     = stage_q.ctrl;

`ifdef DE_REG_STATS_EN
   sat_counter #(.WIDTH(32)) u_stall_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (act == ACT_HOLD),
      .count (stall_cnt)
   );

   sat_counter #(.WIDTH(32)) u_bubble_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (act == ACT_BUBBLE),
      .count (bubble_cnt)
   );

   sat_counter #(.WIDTH(32)) u_flush_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .inc   (act == ACT_FLUSH),
      .count (flush_cnt)
   );
`else
   assign stall_cnt  = '0;
   assign bubble_cnt = '0;
   assign flush_cnt  = '0;
`endif

endmodule

// File: tb/tb_decode_execute_reg.sv
// Bench for decode_execute_reg: directed vector table, hand-written reset/saturation sequences, random vs model.
// Latency: expects e_* one cycle after the sampling edge; checks #1 after each rising edge.
// Backpressure: drives en/no_op/flush on the falling edge like the hazard unit.
module tb_decode_execute_reg;
   import pipeline_pkg::*;

`ifdef DE_REG_STATS_EN
   localparam bit STATS_ON = 1'b1;
`else
   localparam bit STATS_ON = 1'b0;
`endif

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] pc4;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  ra;
      logic [4:0]  rb;
      logic [4:0]  rd;
      logic [6:0]  opcode;
      logic [2:0]  f3;
      logic [10:0] ctrl;
   } stage_t;

   typedef struct {
      bit          en, no_op, flush, d_valid;
      logic [31:0] d_pc;
      logic [4:0]  d_rd;
      logic [6:0]  d_op;
      bit          x_valid;
      logic [31:0] x_pc;
      logic [4:0]  x_rd;
      logic [6:0]  x_op;
      logic [10:0] x_ctrl;
      int          x_stall, x_bubble, x_flush;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n;
   logic en, no_op, flush, d_valid;
   logic [31:0] d_pc, d_pc_plus4, d_rd1, d_rd2, d_imm;
   logic [4:0]  d_reg_a, d_reg_b, d_reg_d;
   logic [6:0]  d_opcode;
   logic [2:0]  d_funct3;
   de_ctrl_t    d_ctrl;
   logic        e_valid;
   logic [31:0] e_pc, e_pc_plus4, e_rd1, e_rd2, e_imm;
   logic [4:0]  e_reg_a, e_reg_b, e_reg_d;
   logic [6:0]  e_opcode;
   logic [2:0]  e_funct3;
   de_ctrl_t    e_ctrl;
   logic [31:0] stall_cnt, bubble_cnt, flush_cnt;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model state
   stage_t      exp_st;
   logic [31:0] exp_stall, exp_bubble, exp_flush;

   always #5 clk = ~clk;

   decode_execute_reg #(.XLEN(32)) dut (
      .clk(clk), .rst_n(rst_n), .en(en), .no_op(no_op), .flush(flush), .d_valid(d_valid),
      .d_pc(d_pc), .d_pc_plus4(d_pc_plus4), .d_rd1(d_rd1), .d_rd2(d_rd2), .d_imm(d_imm),
      .d_reg_a(d_reg_a), .d_reg_b(d_reg_b), .d_reg_d(d_reg_d), .d_opcode(d_opcode),
      .d_funct3(d_funct3), .d_ctrl(d_ctrl),
      .e_valid(e_valid), .e_pc(e_pc), .e_pc_plus4(e_pc_plus4), .e_rd1(e_rd1), .e_rd2(e_rd2),
      .e_imm(e_imm), .e_reg_a(e_reg_a), .e_reg_b(e_reg_b), .e_reg_d(e_reg_d),
      .e_opcode(e_opcode), .e_funct3(e_funct3), .e_ctrl(e_ctrl),
      .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
   );

   task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic stage_t nop_image();
      stage_t s;
      s        = '0;
      s.opcode = 7'b0010011;
      return s;
   endfunction

   function automatic logic [31:0] stat(input logic [31:0] v);
      return STATS_ON ? v : 32'd0;
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction

   function automatic stage_t dut_stage();
      stage_t s;
      s = {e_valid, e_pc, e_pc_plus4, e_rd1, e_rd2, e_imm, e_reg_a, e_reg_b, e_reg_d,
           e_opcode, e_funct3, e_ctrl};
      return s;
   endfunction

   task automatic drive(input bit e, input bit n, input bit f, input stage_t s);
      en = e; no_op = n; flush = f;
      d_valid = s.valid; d_pc = s.pc; d_pc_plus4 = s.pc4; d_rd1 = s.rd1; d_rd2 = s.rd2;
      d_imm = s.imm; d_reg_a = s.ra; d_reg_b = s.rb; d_reg_d = s.rd; d_opcode = s.opcode;
      d_funct3 = s.f3; d_ctrl = s.ctrl;
   endtask

   function automatic stage_t mk_stage(input bit v, input logic [31:0] pc, input logic [4:0] rd,
                                       input logic [6:0] op);
      stage_t s;
      s.valid = v; s.pc = pc; s.pc4 = pc + 32'd4; s.rd1 = pc ^ 32'hA5A5_0000; s.rd2 = ~pc;
      s.imm = pc << 1; s.ra = rd + 5'd1; s.rb = rd + 5'd2; s.rd = rd; s.opcode = op;
      s.f3 = 3'h5; s.ctrl = 11'h5A5;
      return s;
   endfunction

   task automatic model_reset();
      exp_st = nop_image(); exp_stall = '0; exp_bubble = '0; exp_flush = '0;
   endtask

   // One rising edge of the reference behaviour
   task automatic model_edge(input bit e, input bit n, input bit f, input stage_t s);
      if (f) begin
         exp_st = nop_image(); exp_flush = sat_inc(exp_flush);
      end else if (n) begin
         exp_st = nop_image(); exp_bubble = sat_inc(exp_bubble);
      end else if (e) begin
         exp_st = s;
      end else begin
         exp_stall = sat_inc(exp_stall);
      end
   endtask

   task automatic check_model(input string tag);
      check({tag, "_stage"},  dut_stage(), exp_st);
      check({tag, "_stall"},  stall_cnt,   stat(exp_stall));
      check({tag, "_bubble"}, bubble_cnt,  stat(exp_bubble));
      check({tag, "_flush"},  flush_cnt,   stat(exp_flush));
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      model_reset();
   endtask

   vec_t vecs[11];

   initial begin
      stage_t s;
      bit     re, rn, rf;

      rst_n = 1'b0;
      drive(0, 0, 0, '0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      model_reset();
      #1 check_model("reset");

      //          en no fl v  d_pc          rd     op          | v  pc            rd     op          ctrl      st bu fl
      vecs[0]  = '{1, 0, 0, 1, 32'h40, 5'd5,  7'b0110011, 1, 32'h40, 5'd5,  7'b0110011, 11'h5A5, 0, 0, 0};
      vecs[1]  = '{1, 0, 0, 1, 32'h44, 5'd6,  7'b0110011, 1, 32'h44, 5'd6,  7'b0110011, 11'h5A5, 0, 0, 0};
      vecs[2]  = '{0, 0, 0, 1, 32'h48, 5'd6,  7'b0110011, 1, 32'h44, 5'd6,  7'b0110011, 11'h5A5, 1, 0, 0};
      vecs[3]  = '{0, 0, 0, 1, 32'h48, 5'd6,  7'b0110011, 1, 32'h44, 5'd6,  7'b0110011, 11'h5A5, 2, 0, 0};
      vecs[4]  = '{0, 0, 0, 1, 32'h48, 5'd6,  7'b0110011, 1, 32'h44, 5'd6,  7'b0110011, 11'h5A5, 3, 0, 0};
      vecs[5]  = '{0, 1, 0, 1, 32'h4C, 5'd7,  7'b0000011, 0, 32'h0,  5'd0,  7'b0010011, 11'h000, 3, 1, 0};
      vecs[6]  = '{1, 0, 0, 1, 32'h4C, 5'd8,  7'b0000011, 1, 32'h4C, 5'd8,  7'b0000011, 11'h5A5, 3, 1, 0};
      vecs[7]  = '{1, 1, 1, 1, 32'h50, 5'd9,  7'b0110011, 0, 32'h0,  5'd0,  7'b0010011, 11'h000, 3, 1, 1};
      vecs[8]  = '{1, 1, 0, 1, 32'h54, 5'd10, 7'b0110011, 0, 32'h0,  5'd0,  7'b0010011, 11'h000, 3, 2, 1};
      vecs[9]  = '{1, 0, 0, 1, 32'h58, 5'd11, 7'b1101111, 1, 32'h58, 5'd11, 7'b1101111, 11'h5A5, 3, 2, 1};
      vecs[10] = '{0, 0, 1, 1, 32'h5C, 5'd12, 7'b0110011, 0, 32'h0,  5'd0,  7'b0010011, 11'h000, 3, 2, 2};

      for (int i = 0; i < 11; i++) begin
         @(negedge clk);
         drive(vecs[i].en, vecs[i].no_op, vecs[i].flush,
               mk_stage(vecs[i].d_valid, vecs[i].d_pc, vecs[i].d_rd, vecs[i].d_op));
         @(posedge clk);
         #1;
         check($sformatf("vec%0d_valid", i),  e_valid,    vecs[i].x_valid);
         check($sformatf("vec%0d_pc", i),     e_pc,       vecs[i].x_pc);
         check($sformatf("vec%0d_reg_d", i),  e_reg_d,    vecs[i].x_rd);
         check($sformatf("vec%0d_opcode", i), e_opcode,   vecs[i].x_op);
         check($sformatf("vec%0d_ctrl", i),   e_ctrl,     vecs[i].x_ctrl);
         check($sformatf("vec%0d_stall", i),  stall_cnt,  stat(32'(vecs[i].x_stall)));
         check($sformatf("vec%0d_bubble", i), bubble_cnt, stat(32'(vecs[i].x_bubble)));
         check($sformatf("vec%0d_flush", i),  flush_cnt,  stat(32'(vecs[i].x_flush)));
      end

      // Asynchronous reset mid-cycle while a real instruction is loading
      @(negedge clk);
      drive(1, 0, 0, mk_stage(1, 32'h60, 5'd3, 7'b0110011));
      @(posedge clk);
      #1 check("pre_rst_valid", e_valid, 1'b1);
      @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_valid",  e_valid,    1'b0);
      check("async_rst_opcode", e_opcode,   7'b0010011);
      check("async_rst_ctrl",   e_ctrl,     11'h000);
      check("async_rst_pc",     e_pc,       32'h0);
      check("async_rst_stall",  stall_cnt,  32'h0);
      check("async_rst_flush",  flush_cnt,  32'h0);
      // Release in the middle of a stall: first edge holds the NOP image, not pre-reset data
      drive(0, 0, 0, mk_stage(1, 32'h64, 5'd4, 7'b0110011));
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      check("post_rst_pc",    e_pc,      32'h0);
      check("post_rst_valid", e_valid,   1'b0);
      check("post_rst_stall", stall_cnt, stat(32'd1));

`ifdef DE_REG_STATS_EN
      // Saturation of the stall counter
      @(negedge clk);
      drive(0, 0, 0, mk_stage(1, 32'h68, 5'd4, 7'b0110011));
      force dut.u_stall_cnt.cnt_q = 32'hFFFF_FFFE;
      #1 release dut.u_stall_cnt.cnt_q;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1 check($sformatf("sat_stall%0d", k), stall_cnt, 32'hFFFF_FFFF);
      end
`endif

      // Randomised traffic against the reference model
      do_reset();
      for (int c = 0; c < 600; c++) begin
         s.valid = 1'($urandom); s.pc = $urandom; s.pc4 = $urandom; s.rd1 = $urandom;
         s.rd2 = $urandom; s.imm = $urandom; s.ra = 5'($urandom); s.rb = 5'($urandom);
         s.rd = 5'($urandom); s.opcode = 7'($urandom); s.f3 = 3'($urandom);
         s.ctrl = 11'($urandom);
         re = ($urandom_range(0, 3) != 0);
         rn = ($urandom_range(0, 4) == 0);
         rf = ($urandom_range(0, 6) == 0);
         @(negedge clk);
         drive(re, rn, rf, s);
         if ($urandom_range(0, 49) == 0) begin
            #2 rst_n = 1'b0;
            model_reset();
            #1 check("rand_async_rst", dut_stage(), exp_st);
            rst_n = 1'b1;
         end
         @(posedge clk);
         model_edge(re, rn, rf, s);
         #1 check_model("rand");
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

   // Global watchdog so the run always terminates
   initial begin
      #200000;
      n_errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
